// File: rtl/pixel_stream_source.sv
// Raster-order pixel reader across NUM_SOLVERS memories with read-latency realignment and a
// credit-managed output FIFO feeding an Avalon-ST sink. Optional palette: PIXEL_STREAM_PALETTE_EN.
module pixel_stream_source #(
   parameter int unsigned NUM_SOLVERS = 1,
   parameter int unsigned WIDTH       = 640,
   parameter int unsigned HEIGHT      = 480,
   parameter int unsigned RD_LATENCY  = 2,
   parameter int unsigned ITER_WIDTH  = 4,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    en,
   output logic [5:0]              rd_solver_id,
   output logic [18:0]             rd_addr,
   output logic                    rd_req,
   input  logic [ITER_WIDTH-1:0]   rd_data,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic                    out_startofpacket,
   output logic                    out_endofpacket,
   output logic [2*ITER_WIDTH-1:0] out_data,
   output logic                    frame_done
);
   localparam int unsigned NPIX   = WIDTH * HEIGHT;
   localparam int unsigned PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int unsigned DW     = 2 * ITER_WIDTH;
   localparam int unsigned EW     = DW + 2;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

   logic [PIX_W-1:0]      pix_q, pix_d;
   logic [5:0]            sid_q, sid_d;
   logic [18:0]           addr_q, addr_d;
   logic [RD_LATENCY-1:0] sv_q, sv_d, ssop_q, ssop_d, seop_q, seop_d;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [EW-1:0]         mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  frame_done_q, frame_done_d;
   logic                  issue_c, push_c, pop_c;
   logic [CRED_W-1:0]     inflight_c;
   logic [EW-1:0]         wr_entry_c, head_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef PIXEL_STREAM_PALETTE_EN
   logic          pv_q, pv_d;
   logic [EW-1:0] pent_q, pent_d;

   // Max-iteration (in-set) value is black; otherwise RGB332 spread of the iteration count.
   function automatic logic [DW-1:0] pal_entry(input logic [ITER_WIDTH-1:0] k);
      logic [3:0] k4;
      k4 = 4'(k);
      if (k == {ITER_WIDTH{1'b1}}) return '0;
      if (DW == 8) return DW'({k4[3:1], k4[3:1], k4[1:0]});
      return {k, k};
   endfunction

   always_comb begin
      pv_d   = sv_q[RD_LATENCY-1];
      pent_d = {ssop_q[RD_LATENCY-1], seop_q[RD_LATENCY-1], pal_entry(rd_data)};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pv_q   <= 1'b0;
         pent_q <= '0;
      end else begin
         pv_q   <= pv_d;
         pent_q <= pent_d;
      end
   end

   assign push_c     = pv_q;
   assign wr_entry_c = pent_q;
`else
   assign push_c     = sv_q[RD_LATENCY-1];
   assign wr_entry_c = {ssop_q[RD_LATENCY-1], seop_q[RD_LATENCY-1], rd_data, rd_data};
`endif

   // Reads issued but not yet in the FIFO; counted against the FIFO so landing data always fits.
   always_comb begin
      inflight_c = '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
         inflight_c = inflight_c + CRED_W'(sv_q[i]);
      end
`ifdef PIXEL_STREAM_PALETTE_EN
      inflight_c = inflight_c + CRED_W'(pv_q);
`endif
   end

   always_comb begin
      pix_d   = pix_q;
      sid_d   = sid_q;
      addr_d  = addr_q;
      issue_c = !reset && en && ((CRED_W'(count_q) + inflight_c) < CRED_W'(FIFO_DEPTH));
      if (issue_c) begin
         if (pix_q == PIX_W'(NPIX - 1)) begin
            pix_d  = '0;
            sid_d  = '0;
            addr_d = '0;
         end else begin
            pix_d = pix_q + PIX_W'(1);
            if (sid_q == 6'(NUM_SOLVERS - 1)) begin
               sid_d  = '0;
               addr_d = addr_q + 19'(1);
            end else begin
               sid_d = sid_q + 6'(1);
            end
         end
      end
   end

   // Tag pipeline tracks which cycles carry valid rd_data and their frame markers.
   always_comb begin
      sv_d      = sv_q;
      ssop_d    = ssop_q;
      seop_d    = seop_q;
      sv_d[0]   = issue_c;
      ssop_d[0] = issue_c && (pix_q == '0);
      seop_d[0] = issue_c && (pix_q == PIX_W'(NPIX - 1));
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
         sv_d[i]   = sv_q[i-1];
         ssop_d[i] = ssop_q[i-1];
         seop_d[i] = seop_q[i-1];
      end
   end

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      head_c       = mem_q[rd_ptr_q];
      pop_c        = (count_q != '0) && out_ready;
      frame_done_d = pop_c && head_c[EW-2];
      if (push_c) begin
         mem_d[wr_ptr_q] = wr_entry_c;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pix_q        <= '0;
         sid_q        <= '0;
         addr_q       <= '0;
         sv_q         <= '0;
         ssop_q       <= '0;
         seop_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         frame_done_q <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pix_q        <= pix_d;
         sid_q        <= sid_d;
         addr_q       <= addr_d;
         sv_q         <= sv_d;
         ssop_q       <= ssop_d;
         seop_q       <= seop_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         frame_done_q <= frame_done_d;
         mem_q        <= mem_d;
      end
   end

   assign rd_req            = issue_c;
   assign rd_solver_id      = sid_q;
   assign rd_addr           = addr_q;
   assign out_valid         = (count_q != '0);
   assign out_data          = out_valid ? head_c[DW-1:0] : '0;
   assign out_startofpacket = out_valid && head_c[EW-1];
   assign out_endofpacket   = out_valid && head_c[EW-2];
   assign frame_done        = frame_done_q;
endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: 3 solvers, 4x2 frame, memory returns pixel index low bits.
module tb_pixel_stream_source;
   localparam int unsigned NS = 3, W = 4, H = 2, L = 2, IW = 4, FD = 4, NPIX = W * H;
`ifdef PIXEL_STREAM_PALETTE_EN
   localparam int LAT = L + 2;
`else
   localparam int LAT = L + 1;
`endif

   logic        clock, reset, en, rd_req, out_ready, out_valid, out_startofpacket, out_endofpacket, frame_done;
   logic [5:0]  rd_solver_id;
   logic [18:0] rd_addr;
   logic [3:0]  rd_data;
   logic [7:0]  out_data;

   pixel_stream_source #(
      .NUM_SOLVERS(NS), .WIDTH(W), .HEIGHT(H), .RD_LATENCY(L), .ITER_WIDTH(IW), .FIFO_DEPTH(FD)
   ) dut (
      .clock(clock), .reset(reset), .en(en), .rd_solver_id(rd_solver_id), .rd_addr(rd_addr),
      .rd_req(rd_req), .rd_data(rd_data), .out_ready(out_ready), .out_valid(out_valid),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_data(out_data), .frame_done(frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_data(input int unsigned p);
      logic [3:0] k;
      k = 4'(p);
`ifdef PIXEL_STREAM_PALETTE_EN
      if (k == 4'hF) return 8'h00;
      return {k[3:1], k[3:1], k[1:0]};
`else
      return {k, k};
`endif
   endfunction

   // Model state: next pixel to request, next pixel expected on the stream, outstanding credit.
   int          cyc = 0, issued, accepted, req_pix, out_pix, first_req, first_valid, fd_count;
   int          n_log, n_alog;
   logic        prev_eop_acc, hold_prev;
   logic [9:0]  held;
   logic [3:0]  pipe [L];
   logic [7:0]  log_data [8];
   logic        log_sop [8], log_eop [8];
   logic [5:0]  log_sid [8];
   logic [18:0] log_addr [8];
   int unsigned pv;
   logic        acc;

   always @(negedge clock) begin
      cyc++;
      rd_data = pipe[L-1];
      for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pv      = int'(rd_addr) * NS + int'(rd_solver_id);
      pipe[0] = rd_req ? 4'(pv) : 4'h0;
      if (reset) begin
         check("rd_req_in_reset", rd_req, 1'b0);
         issued = 0; accepted = 0; req_pix = 0; out_pix = 0; fd_count = 0;
         first_req = -1; first_valid = -1; n_log = 0; n_alog = 0;
         prev_eop_acc = 1'b0; hold_prev = 1'b0; held = '0;
      end else begin
         check("rd_req", rd_req, en && ((issued - accepted) < int'(FD)));
         check("rd_solver_id", rd_solver_id, 64'(req_pix % NS));
         check("rd_addr", rd_addr, 64'(req_pix / NS));
         check("frame_done", frame_done, prev_eop_acc);
         if (hold_prev) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_beat", {out_data, out_startofpacket, out_endofpacket}, held);
         end
         if (out_valid) begin
            check("beat_data", out_data, exp_data(out_pix));
            check("beat_sop", out_startofpacket, out_pix == 0);
            check("beat_eop", out_endofpacket, out_pix == NPIX - 1);
         end
         if (frame_done) fd_count++;
         if (rd_req && first_req < 0) first_req = cyc;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (rd_req) begin
            if (n_alog < 8) begin
               log_sid[n_alog] = rd_solver_id; log_addr[n_alog] = rd_addr; n_alog++;
            end
            issued++;
            req_pix = (req_pix + 1) % NPIX;
         end
         acc          = out_valid && out_ready;
         prev_eop_acc = acc && (out_pix == NPIX - 1);
         hold_prev    = out_valid && !out_ready;
         held         = {out_data, out_startofpacket, out_endofpacket};
         if (acc) begin
            if (n_log < 8) begin
               log_data[n_log] = out_data; log_sop[n_log] = out_startofpacket;
               log_eop[n_log] = out_endofpacket; n_log++;
            end
            accepted++;
            out_pix = (out_pix + 1) % NPIX;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [15:0] pat = 16'b1001_0011_1001_0001;
   logic [5:0]  exp_sid [8]  = '{0, 1, 2, 0, 1, 2, 0, 1};
   logic [18:0] exp_addr [8] = '{0, 0, 0, 1, 1, 1, 2, 2};
   int          base, iss0;

   initial begin
      for (int i = 0; i < L; i++) pipe[i] = 4'h0;
      rd_data = 4'h0; reset = 1'b1; en = 1'b0; out_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0; en = 1'b1; out_ready = 1'b1;

      // One full frame with the sink always ready.
      for (int i = 0; i < 100 && accepted < 8; i++) step();
      check("p1_beats_done", accepted >= 8, 1'b1);
      for (int i = 0; i < 8; i++) begin
         check("p1_req_sid", log_sid[i], exp_sid[i]);
         check("p1_req_addr", log_addr[i], exp_addr[i]);
      end
      check("p1_first_data", log_data[0], 8'h00);
      check("p1_first_sop", log_sop[0], 1'b1);
`ifdef PIXEL_STREAM_PALETTE_EN
      check("p1_pix6_data", log_data[6], 8'h6E);
      check("p1_last_data", log_data[7], 8'h6F);
`else
      check("p1_pix6_data", log_data[6], 8'h66);
      check("p1_last_data", log_data[7], 8'h77);
`endif
      check("p1_pix6_eop", log_eop[6], 1'b0);
      check("p1_last_eop", log_eop[7], 1'b1);
      check("p1_latency", first_valid - first_req, LAT);
      step(); step();
      check("p1_frame_done_once", fd_count, 1);

      // Three frames under a bursty ready pattern.
      base = accepted;
      for (int i = 0; i < 400 && accepted < base + 24; i++) begin
         out_ready = pat[i % 16];
         step();
      end
      check("p2_beats_done", accepted >= base + 24, 1'b1);
      out_ready = 1'b1;

      // Pause issue just before pixel 3 is requested.
      for (int i = 0; i < 60 && req_pix != 3; i++) step();
      check("p3_reached_pix3", req_pix, 3);
      en = 1'b0;
      iss0 = issued;
      repeat (5) begin
         check("p3_held_sid", rd_solver_id, 6'd0);
         check("p3_held_addr", rd_addr, 19'd1);
         step();
      end
      check("p3_no_issue", issued, iss0);
      en = 1'b1;
      repeat (12) step();
      check("p3_resumed", issued > iss0, 1'b1);

      // Reset right after pixel 5 is accepted.
      for (int i = 0; i < 60 && out_pix != 6; i++) step();
      check("p4_reached_pix5", out_pix, 6);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("p4_valid_after_reset", out_valid, 1'b0);
      check("p4_fd_after_reset", frame_done, 1'b0);
      for (int i = 0; i < 30 && accepted < 1; i++) step();
      check("p4_beat_done", accepted >= 1, 1'b1);
      check("p4_first_data", log_data[0], 8'h00);
      check("p4_first_sop", log_sop[0], 1'b1);
      check("p4_latency", first_valid - first_req, LAT);
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
